// File: rtl/mm_bram_stream_pkg.sv
// Shared types and helpers for the streaming matrix-multiply block.
// Holds the control FSM encoding, the output FIFO depth and saturation.
package gemmt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int SAT_W = 64;

    // Clamp a sign-extended value into a dw-bit signed or unsigned range.
    function automatic logic [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input bit is_signed,
        input int dw
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        if (is_signed) begin
            hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (dw - 1));
        end else begin
            hi = (64'sd1 <<< dw) - 64'sd1;
            lo = 64'sd0;
        end
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mm_bram_stream_if.sv
// Signal bundle around mm_bram_stream: job control, source read port and
// result write stream, with the block side as master.
interface mm_bram_stream_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int LENGTH         = 32,
    parameter int COL_NUM        = 32,
    parameter int ROW_ADDR_WIDTH = 5
);
    logic                           start_val;
    logic                           start_rdy;
    logic [ROW_ADDR_WIDTH:0]        num_rows;
    logic                           rd_en;
    logic [ROW_ADDR_WIDTH-1:0]      rd_addr;
    logic [DATA_WIDTH*LENGTH-1:0]   rd_data;
    logic                           wr_val;
    logic                           wr_rdy;
    logic [ROW_ADDR_WIDTH-1:0]      wr_addr;
    logic [DATA_WIDTH*COL_NUM-1:0]  wr_data;
    logic                           busy;
    logic                           done;

    modport master (
        input  start_val, num_rows, rd_data, wr_rdy,
        output start_rdy, rd_en, rd_addr, wr_val,
        output wr_addr, wr_data, busy, done
    );

    modport slave (
        output start_val, num_rows, rd_data, wr_rdy,
        input  start_rdy, rd_en, rd_addr, wr_val,
        input  wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/mm_bram_stream_dot.sv
// One output column: dot product of a source row with a weight column,
// followed by a right shift and saturation to the element width.
module mm_bram_stream_dot
    import gemmt_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 32,
    parameter int SIGNED     = 1,
    parameter int SHIFT      = 0,
    localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(LENGTH) + 1
) (
    input  logic [DATA_WIDTH*LENGTH-1:0] x,
    input  logic [DATA_WIDTH*LENGTH-1:0] w,
    output logic [DATA_WIDTH-1:0]        y
);

    function automatic logic [ACC_WIDTH-1:0] ext(
        input logic [DATA_WIDTH-1:0] v
    );
        if (SIGNED != 0)
            return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
        return {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, v};
    endfunction

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] shifted;
    logic [SAT_W-1:0]     wide;

    // ACC_WIDTH leaves headroom for the full sum, so wraparound never occurs.
    always_comb begin
        acc = '0;
        for (int i = 0; i < LENGTH; i++) begin
            acc = acc + ext(x[i*DATA_WIDTH +: DATA_WIDTH])
                      * ext(w[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_comb begin
        if (SIGNED != 0) begin
            shifted = $signed(acc) >>> SHIFT;
            wide = {{(SAT_W-ACC_WIDTH){shifted[ACC_WIDTH-1]}}, shifted};
        end else begin
            shifted = acc >> SHIFT;
            wide = {{(SAT_W-ACC_WIDTH){1'b0}}, shifted};
        end
    end

    assign y = DATA_WIDTH'(saturate($signed(wide), SIGNED != 0, DATA_WIDTH));

endmodule

// File: rtl/mm_bram_stream.sv
// Streams source rows from SRAM through COL_NUM dot-product lanes and
// writes result rows out through a 4-entry credit-controlled FIFO.
module mm_bram_stream
    import gemmt_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 32,
    parameter int COL_NUM    = 32,
    parameter int LENGTH     = 32,
    parameter int SIGNED     = 1,
    parameter int SHIFT      = 0,
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM),
    localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(LENGTH) + 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start_val,
    output logic                                  start_rdy,
    input  logic [ROW_ADDR_WIDTH:0]               num_rows,
    input  logic [DATA_WIDTH*LENGTH*COL_NUM-1:0]  weights,
    output logic                                  rd_en,
    output logic [ROW_ADDR_WIDTH-1:0]             rd_addr,
    input  logic [DATA_WIDTH*LENGTH-1:0]          rd_data,
    output logic                                  wr_val,
    input  logic                                  wr_rdy,
    output logic [ROW_ADDR_WIDTH-1:0]             wr_addr,
    output logic [DATA_WIDTH*COL_NUM-1:0]         wr_data,
    output logic                                  busy,
    output logic                                  done
);

    localparam int RW = ROW_ADDR_WIDTH;
    localparam int CW = ROW_ADDR_WIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam int LW = DATA_WIDTH * LENGTH;
    localparam int RDW = DATA_WIDTH * COL_NUM;

    state_t          state;
    logic [CW-1:0]   n_rows;
    logic [CW-1:0]   rd_cnt;
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   req_rows;

    logic            inflight;
    logic [RW-1:0]   inflight_addr;
    logic [OW-1:0]   occ;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [RW-1:0]   fifo_addr [FIFO_DEPTH];
    logic [RDW-1:0]  fifo_data [FIFO_DEPTH];

    logic [RDW-1:0]  row_res;
    logic            credit;
    logic            push;
    logic            pop;
    logic            last_rd;
    logic            last_wr;

    for (genvar j = 0; j < COL_NUM; j++) begin : g_col
        mm_bram_stream_dot #(
            .DATA_WIDTH (DATA_WIDTH),
            .LENGTH     (LENGTH),
            .SIGNED     (SIGNED),
            .SHIFT      (SHIFT)
        ) u_dot (
            .x (rd_data),
            .w (weights[j*LW +: LW]),
            .y (row_res[j*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign req_rows = (num_rows > CW'(ROW_NUM)) ? CW'(ROW_NUM) : num_rows;

    // A pop in the same cycle earns no credit; this keeps the check registered.
    assign credit  = (occ + OW'(inflight)) < OW'(FIFO_DEPTH);
    assign rd_en   = (state == RUN) && credit;
    assign rd_addr = rd_cnt[RW-1:0];
    assign last_rd = rd_en && (rd_cnt == n_rows - CW'(1));

    assign push    = inflight;
    assign wr_val  = (occ != '0);
    assign pop     = wr_val && wr_rdy;
    assign last_wr = pop && (wr_cnt == n_rows - CW'(1));
    assign wr_addr = fifo_addr[rptr];
    assign wr_data = fifo_data[rptr];

    assign start_rdy = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            n_rows <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (pop) wr_cnt <= wr_cnt + CW'(1);
            unique case (state)
                IDLE: begin
                    if (start_val) begin
                        n_rows <= req_rows;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        state  <= (req_rows == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (rd_en) rd_cnt <= rd_cnt + CW'(1);
                    if (last_rd) state <= DRAIN;
                end
                DRAIN: begin
                    if (last_wr) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight      <= 1'b0;
            inflight_addr <= '0;
            occ           <= '0;
            wptr          <= '0;
            rptr          <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            inflight      <= rd_en;
            inflight_addr <= rd_addr;
            if (push) begin
                fifo_addr[wptr] <= inflight_addr;
                fifo_data[wptr] <= row_res;
                wptr            <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr + PW'(1);
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

endmodule

// File: tb/tb_mm_bram_stream.sv
// Directed bench for mm_bram_stream: a signed instance carries most vectors,
// an unsigned SHIFT=10 instance covers the logical-shift path.
module tb_mm_bram_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm_bram_stream_if #(.DATA_WIDTH(8), .LENGTH(4), .COL_NUM(4),
                        .ROW_ADDR_WIDTH(5)) ia ();
    mm_bram_stream_if #(.DATA_WIDTH(8), .LENGTH(4), .COL_NUM(4),
                        .ROW_ADDR_WIDTH(5)) ib ();

    logic [127:0] wa;
    logic [127:0] wb;
    logic [31:0]  src_a [32];
    logic [31:0]  src_b [32];

    mm_bram_stream #(
        .DATA_WIDTH(8), .ROW_NUM(32), .COL_NUM(4),
        .LENGTH(4), .SIGNED(1), .SHIFT(0)
    ) dut_a (
        .clk(clk), .reset(rst_n),
        .start_val(ia.start_val), .start_rdy(ia.start_rdy),
        .num_rows(ia.num_rows), .weights(wa),
        .rd_en(ia.rd_en), .rd_addr(ia.rd_addr), .rd_data(ia.rd_data),
        .wr_val(ia.wr_val), .wr_rdy(ia.wr_rdy),
        .wr_addr(ia.wr_addr), .wr_data(ia.wr_data),
        .busy(ia.busy), .done(ia.done)
    );

    mm_bram_stream #(
        .DATA_WIDTH(8), .ROW_NUM(32), .COL_NUM(4),
        .LENGTH(4), .SIGNED(0), .SHIFT(10)
    ) dut_b (
        .clk(clk), .reset(rst_n),
        .start_val(ib.start_val), .start_rdy(ib.start_rdy),
        .num_rows(ib.num_rows), .weights(wb),
        .rd_en(ib.rd_en), .rd_addr(ib.rd_addr), .rd_data(ib.rd_data),
        .wr_val(ib.wr_val), .wr_rdy(ib.wr_rdy),
        .wr_addr(ib.wr_addr), .wr_data(ib.wr_data),
        .busy(ib.busy), .done(ib.done)
    );

    // Synchronous SRAM models: data one cycle after the strobe.
    always @(posedge clk) begin
        if (ia.rd_en) ia.rd_data <= src_a[ia.rd_addr];
        if (ib.rd_en) ib.rd_data <= src_b[ib.rd_addr];
    end

    logic [4:0]  la_addr [$];
    logic [31:0] la_data [$];
    logic [4:0]  lb_addr [$];
    logic [31:0] lb_data [$];
    int nrd = 0;

    always @(posedge clk) begin
        if (rst_n && ia.wr_val && ia.wr_rdy) begin
            la_addr.push_back(ia.wr_addr);
            la_data.push_back(ia.wr_data);
        end
        if (rst_n && ib.wr_val && ib.wr_rdy) begin
            lb_addr.push_back(ib.wr_addr);
            lb_data.push_back(ib.wr_data);
        end
        if (rst_n && ia.rd_en) nrd <= nrd + 1;
    end

    // Independent occupancy tracking to catch reads beyond FIFO credit.
    int occ_m = 0;
    int infl_m = 0;
    int viol = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_m  <= 0;
            infl_m <= 0;
        end else begin
            if (ia.rd_en && (occ_m + infl_m >= 4)) viol <= viol + 1;
            occ_m  <= occ_m + infl_m - int'(ia.wr_val && ia.wr_rdy);
            infl_m <= int'(ia.rd_en);
        end
    end

    int vec = 0;
    int miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_a(input logic [5:0] n);
        ia.num_rows  = n;
        ia.start_val = 1'b1;
        @(negedge clk);
        ia.start_val = 1'b0;
        ia.num_rows  = ~n;
    endtask

    task automatic wait_done_a(input int lim, output int lat);
        lat = 1;
        while (ia.done !== 1'b1 && lat < lim) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int nrd0;
    logic [15:0] pat = 16'b1001_1001_0110_1001;

    initial begin
        ia.start_val = 1'b0; ia.num_rows = '0; ia.wr_rdy = 1'b1;
        ib.start_val = 1'b0; ib.num_rows = '0; ib.wr_rdy = 1'b1;
        wa = '0;
        wb = '0;
        for (int i = 0; i < 32; i++) begin
            src_a[i] = '0;
            src_b[i] = '0;
        end
        repeat (2) @(negedge clk);

        chk("rst_start_rdy", ia.start_rdy, 1);
        chk("rst_busy", ia.busy, 0);
        chk("rst_done", ia.done, 0);
        chk("rst_rd_en", ia.rd_en, 0);
        chk("rst_wr_val", ia.wr_val, 0);
        chk("rst_rd_addr", ia.rd_addr, 0);
        chk("rst_wr_addr", ia.wr_addr, 0);
        chk("rst_wr_data", ia.wr_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single row: x=[1,2,3,4]; columns [1..], [2..], [-1..], [0,0,0,1].
        wa = 128'h01000000_FFFFFFFF_02020202_01010101;
        src_a[0] = 32'h04030201;
        la_addr.delete(); la_data.delete();
        start_a(6'd1);
        chk("t1_rd_en", ia.rd_en, 1);
        chk("t1_rd_addr", ia.rd_addr, 0);
        chk("t1_busy", ia.busy, 1);
        chk("t1_start_rdy", ia.start_rdy, 0);
        @(negedge clk);
        chk("t1_no_wr_early", ia.wr_val, 0);
        @(negedge clk);
        chk("t1_wr_val", ia.wr_val, 1);
        chk("t1_wr_addr", ia.wr_addr, 0);
        chk("t1_col0", ia.wr_data[7:0], 8'h0A);
        chk("t1_row", ia.wr_data, 32'h04F6140A);
        @(negedge clk);
        chk("t1_done_at_4", ia.done, 1);
        chk("t1_wr_val_off", ia.wr_val, 0);
        @(negedge clk);
        chk("t1_done_pulse", ia.done, 0);
        chk("t1_idle", ia.start_rdy, 1);
        chk("t1_nwr", la_data.size(), 1);

        // Saturation, both directions.
        wa = {16{8'h7F}};
        src_a[0] = 32'h7F7F7F7F;
        src_a[1] = 32'h80808080;
        la_addr.delete(); la_data.delete();
        start_a(6'd2);
        wait_done_a(50, lat);
        chk("t2_latency", lat, 5);
        chk("t2_nwr", la_data.size(), 2);
        chk("t2_pos_sat", la_data[0], 32'h7F7F7F7F);
        chk("t2_neg_sat", la_data[1], 32'h80808080);
        chk("t2_addr1", la_addr[1], 1);

        // Unsigned 255*255*4 = 260100, >>10 = 254.
        wb = {16{8'hFF}};
        src_b[0] = 32'hFFFFFFFF;
        ib.num_rows  = 6'd1;
        ib.start_val = 1'b1;
        @(negedge clk);
        ib.start_val = 1'b0;
        repeat (5) @(negedge clk);
        chk("tb_nwr", lb_data.size(), 1);
        chk("tb_addr", lb_addr[0], 0);
        chk("tb_data", lb_data[0], 32'hFEFEFEFE);

        // 32 rows with back-pressure; row r = [r,0,0,0].
        wa = 128'h01000000_FFFFFFFF_02020202_01010101;
        for (int r = 0; r < 32; r++) src_a[r] = 32'(r);
        la_addr.delete(); la_data.delete();
        start_a(6'd32);
        for (int c = 0; c < 600 && ia.done !== 1'b1; c++) begin
            ia.wr_rdy = pat[c % 16];
            @(negedge clk);
        end
        chk("t3_done", ia.done, 1);
        ia.wr_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_nwr", la_data.size(), 32);
        for (int r = 0; r < 32 && r < la_data.size(); r++) begin
            logic [7:0] v;
            logic [7:0] nv;
            logic [7:0] dv;
            v  = 8'(r);
            nv = 8'(-r);
            dv = 8'(2*r);
            chk($sformatf("t3_addr%0d", r), la_addr[r], 64'(r));
            chk($sformatf("t3_data%0d", r), la_data[r],
                {32'h0, 8'h00, nv, dv, v});
        end
        chk("t3_credit", viol, 0);

        // Zero rows: straight to DONE.
        nrd0 = nrd;
        la_addr.delete(); la_data.delete();
        start_a(6'd0);
        chk("t4_done", ia.done, 1);
        chk("t4_rd_en", ia.rd_en, 0);
        chk("t4_wr_val", ia.wr_val, 0);
        @(negedge clk);
        chk("t4_done_off", ia.done, 0);
        chk("t4_no_reads", nrd - nrd0, 0);
        chk("t4_no_writes", la_data.size(), 0);

        // 40 rows clamps to 32.
        start_a(6'd40);
        wait_done_a(100, lat);
        chk("t4_clamp_latency", lat, 35);
        chk("t4_clamp_nwr", la_data.size(), 32);
        chk("t4_clamp_last", la_addr[la_addr.size()-1], 31);
        @(negedge clk);

        // Reset mid-job after 5 writes with the sink stalled.
        la_addr.delete(); la_data.delete();
        start_a(6'd16);
        for (int c = 0; c < 100 && la_data.size() < 5; c++)
            @(negedge clk);
        ia.wr_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_stalled", ia.wr_val, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_start_rdy", ia.start_rdy, 1);
        chk("t5_busy", ia.busy, 0);
        chk("t5_done", ia.done, 0);
        chk("t5_rd_en", ia.rd_en, 0);
        chk("t5_wr_val", ia.wr_val, 0);
        chk("t5_rd_addr", ia.rd_addr, 0);
        chk("t5_wr_addr", ia.wr_addr, 0);
        chk("t5_wr_data", ia.wr_data, 0);
        chk("t5_nwr", la_data.size(), 5);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ia.wr_rdy = 1'b1;
        la_addr.delete(); la_data.delete();
        @(negedge clk);
        start_a(6'd2);
        wait_done_a(50, lat);
        chk("t5_latency", lat, 5);
        repeat (4) @(negedge clk);
        chk("t5_new_nwr", la_data.size(), 2);
        chk("t5_new_addr0", la_addr[0], 0);
        chk("t5_new_addr1", la_addr[1], 1);
        chk("t5_new_data0", la_data[0], 32'h00000000);
        chk("t5_new_data1", la_data[1], 32'h00FF0201);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/mm_bram_stream.md
MM_BRAM_STREAM -- requirements
Module: mm_bram_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width of input, weight and output.
REQ-002 SHALL have parameter ROW_NUM, default 32, maximum rows per job and source/result SRAM depth.
REQ-003 SHALL have parameter COL_NUM, default 32, output columns.
REQ-004 SHALL have parameter LENGTH, default 32, dot-product length (elements per source row).
REQ-005 SHALL have parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have parameter SHIFT, default 0, right shift applied to each accumulator before saturation.
REQ-007 SHALL have derived parameters ROW_ADDR_WIDTH = $clog2(ROW_NUM) and ACC_WIDTH = 2*DATA_WIDTH + $clog2(LENGTH) + 1; these are not set manually.
REQ-008 SHALL have port clk, input, 1, the single clock for all state.
REQ-009 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-010 SHALL have port start_val, input, 1, job request.
REQ-011 SHALL have port start_rdy, output, 1, high only in IDLE.
REQ-012 SHALL have port num_rows, input, ROW_ADDR_WIDTH+1, row count, sampled on start handshake.
REQ-013 SHALL have port weights, input, DATA_WIDTH*LENGTH*COL_NUM; element (i,j) at bits [(j*LENGTH+i)*DATA_WIDTH +: DATA_WIDTH]; held stable while busy.
REQ-014 SHALL have port rd_en, output, 1, source SRAM read strobe.
REQ-015 SHALL have port rd_addr, output, ROW_ADDR_WIDTH, source row address.
REQ-016 SHALL have port rd_data, input, DATA_WIDTH*LENGTH; element i at [i*DATA_WIDTH +: DATA_WIDTH]; valid exactly 1 cycle after rd_en.
REQ-017 SHALL have port wr_val, output, 1, result row valid.
REQ-018 SHALL have port wr_rdy, input, 1, result sink ready.
REQ-019 SHALL have port wr_addr, output, ROW_ADDR_WIDTH, result row address.
REQ-020 SHALL have port wr_data, output, DATA_WIDTH*COL_NUM; column j at [j*DATA_WIDTH +: DATA_WIDTH].
REQ-021 SHALL have port busy, output, 1, high outside IDLE.
REQ-022 SHALL have port done, output, 1, one-cycle job-complete pulse.

Function
REQ-023 FSM SHALL have states IDLE, RUN, DRAIN, DONE; start_val&&start_rdy moves IDLE->RUN; last read issued moves RUN->DRAIN; last write handshake moves DRAIN->DONE; DONE->IDLE unconditionally after 1 cycle, and done=1 only in DONE.
REQ-024 On the start handshake, num_rows SHALL be latched and clamped to ROW_NUM; a latched value of 0 SHALL go IDLE->DONE directly with no reads and no writes.
REQ-025 Rows SHALL be read in order at addresses 0..num_rows-1; row r SHALL be written to wr_addr r, in order.
REQ-026 Column j of row r SHALL be the sum over i of x[r][i]*w[i][j], computed in ACC_WIDTH bits with no overflow, signed or unsigned per SIGNED.
REQ-027 Each accumulator SHALL be arithmetically (SIGNED=1) or logically (SIGNED=0) shifted right by SHIFT, then saturated to DATA_WIDTH: signed range [-2^(DW-1), 2^(DW-1)-1] or unsigned range [0, 2^DW-1].
REQ-028 The pipeline SHALL be: rd_en at cycle t, rd_data at t+1, result registered into a 4-entry output FIFO at the end of t+1, earliest wr_val at t+2.
REQ-029 wr_val SHALL equal FIFO non-empty; wr_addr and wr_data SHALL show the FIFO head; a pop SHALL occur only on wr_val&&wr_rdy.
REQ-030 A read SHALL issue only when registered FIFO occupancy + reads in flight < 4, with no credit given for a same-cycle pop, so the FIFO never overflows.
REQ-031 With wr_rdy held at 1, throughput SHALL be one row per cycle: job latency from the start handshake to done = num_rows + 3 cycles.
REQ-032 Outputs SHALL stay stable while wr_val=1 and wr_rdy=0.
REQ-033 start_val SHALL be ignored outside IDLE.
REQ-034 num_rows changes after the start handshake SHALL have no effect.

Reset
REQ-035 Assertion of reset (low) SHALL immediately force IDLE, clear FIFO contents, pointers, counters and in-flight flags, and drive start_rdy=1 and rd_en=0, wr_val=0, busy=0, done=0, rd_addr=0, wr_addr=0, wr_data=0.
REQ-036 Reset mid-job SHALL abandon the job with no further writes; the first start after reset deasserts SHALL begin from row 0.

Structure
REQ-037 Shared package gemmt_pkg SHALL hold the FSM state enum, the FIFO depth constant (4) and a saturate function parametrised by SIGNED.
REQ-038 Sub-module mm_bram_stream_dot SHALL compute one column (dot product, shift, saturate) and SHALL be instantiated COL_NUM times by generate.

Verification
REQ-039 The bench SHALL cover: DW=8, SIGNED=1, LENGTH=4, x=[1,2,3,4], w column 0=[1,1,1,1], num_rows=1, wr_rdy=1 -> wr_data col0=10, wr_addr=0, done 4 cycles after start.
REQ-040 The bench SHALL cover: SIGNED=1, all x=127, all w=127, SHIFT=0 -> every column=127 (saturated); all x=-128, w=127 -> -128.
REQ-041 The bench SHALL cover: SIGNED=0, x=255, w=255, LENGTH=4, SHIFT=10 -> 254 (260100>>10).
REQ-042 The bench SHALL cover: num_rows=32, wr_rdy toggling 1-0-0-1 pseudo-randomly -> exactly 32 writes, addresses 0..31 in order, no loss or duplication, rd_en never issued with occupancy+inflight>=4.
REQ-043 The bench SHALL cover: num_rows=0 -> done pulse 1 cycle after start, no rd_en, no wr_val; num_rows=40 with ROW_NUM=32 -> 32 writes.
REQ-044 The bench SHALL cover: reset asserted after 5 of 16 rows written, with wr_rdy=0 -> all outputs at reset values at once; a new job with num_rows=2 writes rows 0,1 only.
